// File: rtl/bcd_pkg.sv
// Shared types and helpers for the serial packed-BCD add/subtract controller.
// Latency: n/a (types, constants and pure combinational functions only).
// Backpressure: n/a.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Nine's complement of a decimal digit; only meaningful for d <= 9.
  function automatic logic [3:0] nines_comp(input logic [3:0] d);
    return 4'd9 - d;
  endfunction

  function automatic logic digit_valid(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder with carry-in and carry-out.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; outputs follow inputs.
// Ports: x, y - BCD digits (0..9); cin - decimal carry in;
//        sum - BCD digit result; cout - decimal carry out.
module bcd_digit_add (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] bin;
  logic [4:0] corr;

  always_comb begin
    bin  = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    // A binary sum above 9 skips the six unused codes 10..15 to wrap into
    // the next decade; the largest input 9+9+1=19 still fits in 5 bits.
    corr = bin + 5'd6;
    if (bin > 5'd9) begin
      sum  = corr[3:0];
      cout = 1'b1;
    end else begin
      sum  = bin[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_alu_ctrl.sv
// Serial packed-BCD add/subtract, one digit per clock through one shared adder.
// Latency: done DIGITS cycles after accept (2*DIGITS if the difference is
//          negative, same cycle-after-accept if an operand digit is invalid).
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
// Ports: clk, rst_n (sync, active-low); start/op/a/b request; busy, done
//        pulse, result, carry_out, sign_neg, invalid registered outputs.
module bcd_serial_alu_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  carry_out,
  output logic                  sign_neg,
  output logic                  invalid
);

  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t                state;
  logic [IW-1:0]         idx;
  logic                  carry;
  logic                  op_q;
  logic [4*DIGITS-1:0]   a_q;
  logic [4*DIGITS-1:0]   b_q;

  logic [3:0] a_dig, b_dig, r_dig;
  logic [3:0] add_x, add_y, add_sum;
  logic       add_cout;
  logic       any_bad;

  // Digit select at idx and operand validity check on the live inputs.
  always_comb begin
    a_dig   = 4'd0;
    b_dig   = 4'd0;
    r_dig   = 4'd0;
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        a_dig = a_q[i*4 +: 4];
        b_dig = b_q[i*4 +: 4];
        r_dig = result[i*4 +: 4];
      end
      if (!digit_valid(a[i*4 +: 4]) || !digit_valid(b[i*4 +: 4])) begin
        any_bad = 1'b1;
      end
    end
  end

  // FIX rewrites the stored result as 9's complement + 1 (ten's complement),
  // turning the wrapped negative difference into its magnitude.
  always_comb begin
    if (state == FIX) begin
      add_x = nines_comp(r_dig);
      add_y = 4'd0;
    end else begin
      add_x = a_dig;
      add_y = (op_q == OP_SUB) ? nines_comp(b_dig) : b_dig;
    end
  end

  bcd_digit_add u_add (
    .x    (add_x),
    .y    (add_y),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      op_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      sign_neg  <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            op_q      <= op;
            result    <= '0;
            carry_out <= 1'b0;
            sign_neg  <= 1'b0;
            idx       <= '0;
            if (any_bad) begin
              invalid <= 1'b1;
              carry   <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              invalid <= 1'b0;
              carry   <= op;   // subtract: 9's complement plus carry-in 1
              busy    <= 1'b1;
              state   <= RUN;
            end
          end
        end

        RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) result[i*4 +: 4] <= add_sum;
          end
          carry <= add_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            idx <= '0;
            if (op_q == OP_ADD) begin
              carry_out <= add_cout;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else if (add_cout) begin
              // End-around carry present: A >= B, result already final.
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              sign_neg <= 1'b1;
              carry    <= 1'b1;
              state    <= FIX;
            end
          end
        end

        FIX: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) result[i*4 +: 4] <= add_sum;
          end
          carry <= add_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_alu_ctrl.sv
// Scoreboard bench for bcd_serial_alu_ctrl: directed cases plus random ops.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_bcd_serial_alu_ctrl;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         sign_neg;
  logic         invalid;

  always #5 clk = ~clk;

  bcd_serial_alu_ctrl #(.DIGITS(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .sign_neg  (sign_neg),
    .invalid   (invalid)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         sn;
    logic         inv;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain decimal arithmetic) ----------------
  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint n);
    logic [W-1:0] r = '0;
    longint m = n;
    for (int i = 0; i < D; i++) begin
      r[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    bit f = 0;
    for (int i = 0; i < D; i++) if (v[i*4 +: 4] > 4'd9) f = 1;
    return f;
  endfunction

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mop);
    exp_t e;
    longint pw = 1;
    longint av, bv, s;
    for (int i = 0; i < D; i++) pw = pw * 10;
    e.res = '0; e.co = 0; e.sn = 0; e.inv = 0; e.lat = D; e.acc = 0;
    if (has_bad(ma) || has_bad(mb)) begin
      e.inv = 1;
      e.lat = 0;
    end else begin
      av = bcd2int(ma);
      bv = bcd2int(mb);
      if (!mop) begin
        s     = av + bv;
        e.res = int2bcd(s % pw);
        e.co  = (s >= pw);
      end else begin
        s = av - bv;
        if (s < 0) begin
          e.sn  = 1;
          e.res = int2bcd(-s);
          e.lat = 2 * D;
        end else begin
          e.res = int2bcd(s);
        end
      end
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
        end else begin
          mon_e = q.pop_front();
          check("result",    64'(result),    64'(mon_e.res));
          check("carry_out", 64'(carry_out), 64'(mon_e.co));
          check("sign_neg",  64'(sign_neg),  64'(mon_e.sn));
          check("invalid",   64'(invalid),   64'(mon_e.inv));
          check("latency",   64'(cyc - mon_e.acc), 64'(mon_e.lat));
          check("busy_cycles", 64'(busy_cnt), 64'(mon_e.lat));
        end
        busy_cnt = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic top, input bit poke);
    exp_t e;
    bit   seen = 0;
    @(negedge clk);
    a = ta; b = tb_; op = top; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = model(ta, tb_, top);
    e.acc = cyc;
    q.push_back(e);
    // operands may change freely once accepted
    a  = W'($urandom);
    b  = W'($urandom);
    op = 1'($urandom);
    if (poke && e.lat > 1) begin
      @(negedge clk);
      start = 1'b1;            // lands during RUN: must be ignored
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    for (int n = 0; n < 3 * D + 8 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout actual=0 expected=1 (t=%0t)", $time);
      q.delete();
    end else if (poke) begin
      start = 1'b1;            // sampled at the edge that leaves DONE: ignored
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < D; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && ($urandom_range(0, 9) == 0))
      v[$urandom_range(0, D - 1)*4 +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",    64'(busy),      64'(0));
    check("rst_done",    64'(done),      64'(0));
    check("rst_result",  64'(result),    64'(0));
    check("rst_carry",   64'(carry_out), 64'(0));
    check("rst_sign",    64'(sign_neg),  64'(0));
    check("rst_invalid", 64'(invalid),   64'(0));
    rst_n = 1'b1;

    // directed cases
    run_op(16'h1234, 16'h5678, 1'b0, 1'b0);
    run_op(16'h9999, 16'h0001, 1'b0, 1'b0);
    run_op(16'h5000, 16'h1234, 1'b1, 1'b0);
    run_op(16'h0345, 16'h0345, 1'b1, 1'b0);
    run_op(16'h0012, 16'h0345, 1'b1, 1'b1);
    run_op(16'h12A4, 16'h0001, 1'b0, 1'b0);
    run_op(16'h0100, 16'h00F3, 1'b1, 1'b0);
    run_op(16'h0000, 16'h9999, 1'b1, 1'b1);

    // reset two edges into a negative subtract: no done pulse follows
    @(negedge clk);
    a = 16'h0012; b = 16'h0345; op = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy",    64'(busy),      64'(0));
    check("midrst_done",    64'(done),      64'(0));
    check("midrst_result",  64'(result),    64'(0));
    check("midrst_carry",   64'(carry_out), 64'(0));
    check("midrst_sign",    64'(sign_neg),  64'(0));
    check("midrst_invalid", 64'(invalid),   64'(0));
    rst_n = 1'b1;
    repeat (3 * D) @(negedge clk);
    run_op(16'h0050, 16'h0049, 1'b1, 1'b0);

    // random traffic
    for (int n = 0; n < 60; n++) begin
      run_op(rand_bcd(1), rand_bcd(1), 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    repeat (10) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_serial_alu_ctrl.md
# bcd_serial_alu_ctrl

Sequencing controller that performs multi-digit packed-BCD addition and subtraction one digit per clock through a single shared one-digit BCD adder. Subtraction uses nine's complement of B with carry-in 1. A negative result triggers a second serial pass that converts the result to sign plus magnitude. It sits between a register or keypad front end and the seven-segment display path, with a start/done handshake.

## Interface
Parameters:
- DIGITS, 4: number of BCD digits per operand; legal range 2–8.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = add (A+B), 1 = subtract (A−B).
- a  in  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
- b  in  4*DIGITS  operand B, packed BCD.
- busy  out  1  high from accept edge until DONE is entered.
- done  out  1  one-cycle pulse; result fields valid.
- result  out  4*DIGITS  sum, or difference magnitude, packed BCD.
- carry_out  out  1  add overflow (final decimal carry); 0 for subtract.
- sign_neg  out  1  subtract result negative (A<B); 0 for add.
- invalid  out  1  an operand digit was >9 at accept.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 latches a, b, op and clears result and flags.
  - Any digit of a or b greater than 9 sets invalid=1, forces result=0, and goes to DONE.
  - Otherwise: idx=0, carry = op (1 for subtract), go to RUN.
- RUN, one digit per cycle at idx:
  - Adder inputs: a[idx], op ? (9 − b[idx]) : b[idx], carry.
  - Write the digit sum to result[idx]; carry takes the digit carry-out; idx increments.
  - After digit DIGITS−1:
    - Add: carry_out = final carry, go to DONE.
    - Subtract, final carry=1: result is non-negative, sign_neg=0, go to DONE.
    - Subtract, final carry=0: sign_neg=1, idx=0, carry=1, go to FIX.
- FIX, one digit per cycle:
  - Adder inputs: (9 − result[idx]), 0, carry.
  - Write the sum back to result[idx]; this yields the ten's complement, i.e. the magnitude.
  - After the last digit, go to DONE.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE unconditionally.
  - result and flags hold until the next accepted start.
- start outside IDLE is ignored, including during DONE.
- op, a and b may change freely after accept.
- A==B subtract gives result 0 and sign_neg=0. Negative zero never occurs.
- Add overflow: result holds the low DIGITS digits, carry_out=1.

## Timing
- Reset (rst_n=0 at an edge): state IDLE; busy=0, done=0, result=0, carry_out=0, sign_neg=0, invalid=0; idx=0, carry=0. Reset mid-operation abandons the operation with no done pulse.
- Accept at edge k: busy=1 from k.
- Latency, cycles in which done=1:
  - Add, or non-negative subtract: cycle after edge k+DIGITS.
  - Negative subtract: cycle after edge k+2·DIGITS.
  - Invalid operands: cycle after edge k.
- busy=0 in the DONE cycle. The earliest next accept is the edge following DONE.
- result digits update progressively during RUN/FIX and are defined only while done=1 or afterwards in IDLE.

## Structure
- Shared package bcd_pkg holds:
  - state enum {IDLE, RUN, FIX, DONE};
  - op encodings OP_ADD=0, OP_SUB=1;
  - function nines_comp(d) = 9 − d;
  - function digit_valid(d) = d ≤ 9.
- One sub-module, bcd_digit_add: combinational 4-bit BCD add with carry-in, producing digit sum (4 bits) and carry-out, with +6 correction when the binary sum exceeds 9. It is instantiated once and muxed between RUN and FIX.
- idx counter width: $clog2(DIGITS).

## Test plan
- DIGITS=4, add 1234+5678, start at edge k -> done in the cycle after edge k+4, result=6912, carry_out=0, sign_neg=0.
- Add 9999+0001 -> result=0000, carry_out=1, done after k+4.
- Subtract 5000−1234 -> result=3766, sign_neg=0, done after k+4. Subtract 0345−0345 -> result=0000, sign_neg=0.
- Subtract 0012−0345 -> result=0333, sign_neg=1, done after k+8; busy high for exactly 8 cycles.
- a=0x12A4 -> invalid=1, result=0, done after k; b with digit 0xF behaves the same.
- start pulsed during RUN and during DONE -> ignored, single done pulse. rst_n=0 at edge k+2 -> all outputs 0 next cycle, no done pulse; a new start then completes normally.
